// File: rtl/arbitro_mux2a1.sv
// Round-robin valid/ready arbiter feeding the 2:1 mux: drives s0 and a registered F.
// Build option ARBITRO_PRIO_FIJA_EN selects fixed priority (A wins every tie).
module arbitro_mux2a1 #(
    parameter int W  = 3,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  A,
    input  logic          valid_a,
    output logic          ready_a,
    input  logic [W-1:0]  B,
    input  logic          valid_b,
    output logic          ready_b,
    output logic [W-1:0]  F,
    output logic          valid_f,
    input  logic          ready_f,
    output logic          s0,
    output logic [CW-1:0] cuenta
);

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    estado_t       estado_r;
    logic [W-1:0]  f_r;
    logic          s0_r;
    logic [CW-1:0] cuenta_r;
    logic          ultimo_r;

    logic          carga_s;
    logic          grant_a_s;
    logic          grant_b_s;
    logic          grant_s;
    logic [W-1:0]  dato_s;

    // Output slot can take a word when empty or draining; nothing is taken during reset
    always_comb begin
        carga_s = rst_n && ((estado_r == VACIO) || ready_f);
    end

    // Grant selection from the two valids only, so ready_* never depends on ready_*
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        case ({valid_a, valid_b})
            2'b10: grant_a_s = 1'b1;
            2'b01: grant_b_s = 1'b1;
            2'b11: begin
`ifdef ARBITRO_PRIO_FIJA_EN
                grant_a_s = 1'b1;
`else
                if (ultimo_r) begin
                    grant_a_s = 1'b1;
                end else begin
                    grant_b_s = 1'b1;
                end
`endif
            end
            default: begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        endcase
    end

    // Handshake strobes and the word that loads into F on a grant
    always_comb begin
        ready_a = carga_s & grant_a_s;
        ready_b = carga_s & grant_b_s;
        grant_s = ready_a | ready_b;
        if (grant_b_s) begin
            dato_s = B;
        end else begin
            dato_s = A;
        end
    end

    // Output-register FSM: VACIO/LLENO track valid_f; a grant loads F, s0, ultimo, cuenta
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= VACIO;
            f_r      <= {W{1'b0}};
            s0_r     <= 1'b0;
            cuenta_r <= {CW{1'b0}};
            ultimo_r <= 1'b1;
        end else begin
            case (estado_r)
                VACIO: begin
                    if (grant_s) begin
                        estado_r <= LLENO;
                        f_r      <= dato_s;
                        s0_r     <= grant_b_s;
                        ultimo_r <= grant_b_s;
                        cuenta_r <= cuenta_r + CW'(1);
                    end else begin
                        estado_r <= VACIO;
                    end
                end
                LLENO: begin
                    if (ready_f && grant_s) begin
                        estado_r <= LLENO;
                        f_r      <= dato_s;
                        s0_r     <= grant_b_s;
                        ultimo_r <= grant_b_s;
                        cuenta_r <= cuenta_r + CW'(1);
                    end else if (ready_f) begin
                        estado_r <= VACIO;
                    end else begin
                        estado_r <= LLENO;
                    end
                end
                default: begin
                    estado_r <= VACIO;
                end
            endcase
        end
    end

    assign F       = f_r;
    assign valid_f = (estado_r == LLENO);
    assign s0      = s0_r;
    assign cuenta  = cuenta_r;

endmodule

// File: tb/tb_arbitro_mux2a1.sv
// Directed self-checking bench for arbitro_mux2a1; a second instance with CW=2 covers counter wrap.
module tb_arbitro_mux2a1;

    logic       clk;
    logic       rst_n;
    logic [2:0] A;
    logic [2:0] B;
    logic       valid_a;
    logic       valid_b;
    logic       ready_f;
    logic       ready_a;
    logic       ready_b;
    logic [2:0] F;
    logic       valid_f;
    logic       s0;
    logic [7:0] cuenta;
    logic       ready_a_w;
    logic       ready_b_w;
    logic [2:0] f_w;
    logic       valid_f_w;
    logic       s0_w;
    logic [1:0] cuenta_w;

    int n_chk;
    int n_fail;

    arbitro_mux2a1 #(.W(3), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .A(A), .valid_a(valid_a), .ready_a(ready_a),
        .B(B), .valid_b(valid_b), .ready_b(ready_b),
        .F(F), .valid_f(valid_f), .ready_f(ready_f),
        .s0(s0), .cuenta(cuenta)
    );

    arbitro_mux2a1 #(.W(3), .CW(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .A(A), .valid_a(valid_a), .ready_a(ready_a_w),
        .B(B), .valid_b(valid_b), .ready_b(ready_b_w),
        .F(f_w), .valid_f(valid_f_w), .ready_f(ready_f),
        .s0(s0_w), .cuenta(cuenta_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        ready_f = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        A       = 3'b000;
        B       = 3'b000;
        valid_a = 1'b0;
        valid_b = 1'b0;
        ready_f = 1'b0;
        #1;
        chk("rst_F", 32'(F), 32'd0);
        chk("rst_valid_f", 32'(valid_f), 32'd0);
        chk("rst_s0", 32'(s0), 32'd0);
        chk("rst_cuenta", 32'(cuenta), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source A
        A = 3'b101; valid_a = 1'b1; valid_b = 1'b0; ready_f = 1'b1;
        #1;
        chk("single_ready_a", 32'(ready_a), 32'd1);
        chk("single_ready_b", 32'(ready_b), 32'd0);
        tick();
        valid_a = 1'b0;
        chk("single_F", 32'(F), 32'h5);
        chk("single_s0", 32'(s0), 32'd0);
        chk("single_valid_f", 32'(valid_f), 32'd1);
        chk("single_cuenta", 32'(cuenta), 32'd1);
        tick();
        chk("drain_valid_f", 32'(valid_f), 32'd0);
        chk("drain_F_hold", 32'(F), 32'h5);

        // Tie between A and B for 4 cycles
        do_reset();
        A = 3'b011; B = 3'b100; valid_a = 1'b1; valid_b = 1'b1; ready_f = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_b;
`ifdef ARBITRO_PRIO_FIJA_EN
            exp_b = 1'b0;
`else
            exp_b = (i % 2) == 1;
`endif
            #1;
            chk("tie_ready_a", 32'(ready_a), 32'(!exp_b));
            chk("tie_ready_b", 32'(ready_b), 32'(exp_b));
            tick();
            chk("tie_s0", 32'(s0), 32'(exp_b));
            chk("tie_F", 32'(F), exp_b ? 32'h4 : 32'h3);
        end
        valid_a = 1'b0; valid_b = 1'b0;
        chk("tie_cuenta", 32'(cuenta), 32'd4);

        // Stall with a pending A word
        do_reset();
        A = 3'b010; valid_a = 1'b1; ready_f = 1'b1;
        tick();
        chk("stall_load_F", 32'(F), 32'h2);
        A = 3'b111; ready_f = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready_a", 32'(ready_a), 32'd0);
            tick();
            chk("stall_F", 32'(F), 32'h2);
            chk("stall_s0", 32'(s0), 32'd0);
            chk("stall_cuenta", 32'(cuenta), 32'd1);
            chk("stall_valid_f", 32'(valid_f), 32'd1);
        end
        ready_f = 1'b1;
        #1;
        chk("unstall_ready_a", 32'(ready_a), 32'd1);
        tick();
        chk("unstall_F", 32'(F), 32'h7);
        chk("unstall_cuenta", 32'(cuenta), 32'd2);

        // Asynchronous reset mid-stream
        A = 3'b101; ready_f = 1'b0;
        tick();
        chk("pre_rst_valid_f", 32'(valid_f), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_F", 32'(F), 32'd0);
        chk("async_valid_f", 32'(valid_f), 32'd0);
        chk("async_s0", 32'(s0), 32'd0);
        chk("async_cuenta", 32'(cuenta), 32'd0);
        chk("async_ready_a", 32'(ready_a), 32'd0);
        tick();
        chk("held_rst_cuenta", 32'(cuenta), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap on the CW=2 instance, back-to-back A words
        A = 3'b001; valid_a = 1'b1; valid_b = 1'b0; ready_f = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("wrap_cuenta_w", 32'(cuenta_w), 32'(i % 4));
            chk("wrap_cuenta", 32'(cuenta), 32'(i));
        end

        // Single source B
        valid_a = 1'b0; valid_b = 1'b1; B = 3'b110;
        #1;
        chk("b_ready_b", 32'(ready_b), 32'd1);
        chk("b_ready_a", 32'(ready_a), 32'd0);
        tick();
        valid_b = 1'b0;
        chk("b_F", 32'(F), 32'h6);
        chk("b_s0", 32'(s0), 32'd1);
        chk("b_cuenta", 32'(cuenta), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
